fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end; successor to the single-cycle PC block.
- Owns the program counter and issues one-outstanding-request reads to the instruction cache.
- Buffers returned words in a QUEUE_DEPTH FIFO and presents them to the Controller over a valid/ready handshake.
- Resolves branch/unconditional-branch redirects with a queue flush and discard of any in-flight fetch.

---
 rtl/fetch_unit_if.sv | 50 +++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle.
//
// Groups the instruction-cache request channel, the branch-resolution
// inputs and the instruction-queue output channel of fetch_unit.
//   master : the fetch unit (drives imemReq/imemAddr, instValid/instData/
//            instPc, queueCount)
//   slave  : the environment (instruction cache, execute stage, Controller)
//
// Handshakes:
//   imem : imemReq rises with imemAddr; both are held unchanged until the
//          cycle in which imemAck is high. imemData is valid only in that
//          cycle. At most one request is outstanding.
//   inst : valid/ready. A transfer happens on a rising clock edge where
//          instValid & instReady are both high. instData/instPc are
//          meaningful only while instValid is high; instReady while
//          instValid is low has no effect.
interface fetch_unit_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int COUNT_WIDTH = $clog2(QUEUE_DEPTH) + 1;

  logic                   imemReq;
  logic [ADDR_WIDTH-1:0]  imemAddr;
  logic                   imemAck;
  logic [DATA_WIDTH-1:0]  imemData;
  logic                   branchFlag;
  logic                   unconditionalBranchFlag;
  logic                   zeroFlag;
  logic [ADDR_WIDTH-1:0]  branchPc;
  logic [ADDR_WIDTH-1:0]  branchOffset;
  logic                   instValid;
  logic [DATA_WIDTH-1:0]  instData;
  logic [ADDR_WIDTH-1:0]  instPc;
  logic                   instReady;
  logic [COUNT_WIDTH-1:0] queueCount;

  modport master (
    output imemReq, imemAddr, instValid, instData, instPc, queueCount,
    input  imemAck, imemData, branchFlag, unconditionalBranchFlag, zeroFlag,
           branchPc, branchOffset, instReady
  );

  modport slave (
    input  imemReq, imemAddr, instValid, instData, instPc, queueCount,
    output imemAck, imemData, branchFlag, unconditionalBranchFlag, zeroFlag,
           branchPc, branchOffset, instReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
//
// Owns the program counter, issues one-outstanding-request reads to the
// instruction cache, buffers returned words in a QUEUE_DEPTH-entry circular
// queue and presents the head to the Controller. A taken branch (or an
// unconditional branch) flushes the queue and discards any in-flight fetch.
//
// Ports:
//   clock       : rising-edge clock
//   resetN      : asynchronous active-low reset
//   bus         : fetch_unit_if master (imem request, branch inputs,
//                 instruction queue output, occupancy)
//   debug_state : current FSM state (0 IDLE, 1 WAIT, 2 DROP)
module fetch_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    PC_STEP     = 4
) (
  input  logic              clock,
  input  logic              resetN,
  fetch_unit_if.master      bus,
  output logic [1:0]        debug_state
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;

  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] next_seq_pc;
  logic                  pop;
  logic                  push;
  logic [CW-1:0]         count_after_pop;
  logic                  space_idle;
  logic                  space_ack;

  always_comb begin
    redirect        = bus.unconditionalBranchFlag | (bus.branchFlag & bus.zeroFlag);
    target          = bus.branchPc + (bus.branchOffset << 2);
    next_seq_pc     = fetch_pc + ADDR_WIDTH'(PC_STEP);
    pop             = (count != '0) && bus.instReady;
    push            = (state == WAIT) && bus.imemAck && !redirect;
    count_after_pop = count - CW'(pop);
    space_idle      = count_after_pop < CW'(QUEUE_DEPTH);
    // On the ack cycle the returning word takes a slot before a re-issue
    // can reserve the next one.
    space_ack       = (count_after_pop + CW'(1)) < CW'(QUEUE_DEPTH);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      bus.imemReq  <= 1'b0;
      bus.imemAddr <= RESET_PC;
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      // Queue bookkeeping; a flush overrides push and pop.
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target;
          end else if (space_idle) begin
            bus.imemReq  <= 1'b1;
            bus.imemAddr <= fetch_pc;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imemAck) begin
            if (redirect) begin
              fetch_pc    <= target;
              bus.imemReq <= 1'b0;
              state       <= IDLE;
            end else begin
              fetch_pc <= next_seq_pc;
              if (space_ack) begin
                // Back-to-back: imemReq stays high with the new address.
                bus.imemAddr <= next_seq_pc;
              end else begin
                bus.imemReq <= 1'b0;
                state       <= IDLE;
              end
            end
          end else if (redirect) begin
            // Request must stay stable until acked; its data is discarded.
            fetch_pc <= target;
            state    <= DROP;
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= target;
          if (bus.imemAck) begin
            bus.imemReq <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          bus.imemReq <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Queue storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      q_data[wr_ptr] <= bus.imemData;
      q_pc[wr_ptr]   <= bus.imemAddr;
    end
  end

  assign bus.instValid  = (count != '0);
  assign bus.instData   = (count != '0) ? q_data[rd_ptr] : '0;
  assign bus.instPc     = (count != '0) ? q_pc[rd_ptr] : '0;
  assign bus.queueCount = count;
  assign debug_state    = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized phase.
// A transaction-level model tracks the expected fetch address stream, the
// expected instruction stream seen by the Controller and queue occupancy.
module tb_fetch_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int QD = 4;
  localparam logic [31:0] RESET2 = 32'hFFFF_FFF8;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic [1:0] state1;
  logic [1:0] state2;

  always #5 clock = ~clock;

  fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD)) bus ();
  fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD)) bus2 ();

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD),
               .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clock(clock), .resetN(resetN), .bus(bus), .debug_state(state1));

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD),
               .RESET_PC(RESET2), .PC_STEP(4)) dut2 (
    .clock(clock), .resetN(resetN), .bus(bus2), .debug_state(state2));

  // Second instance: ideal cache (ack in the request cycle, data = address).
  assign bus2.imemAck                 = bus2.imemReq;
  assign bus2.imemData                = bus2.imemAddr;
  assign bus2.branchFlag              = 1'b0;
  assign bus2.unconditionalBranchFlag = 1'b0;
  assign bus2.zeroFlag                = 1'b0;
  assign bus2.branchPc                = '0;
  assign bus2.branchOffset            = '0;
  assign bus2.instReady               = 1'b1;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] exp_fetch;   // address of the next useful request
  logic [31:0] exp_pc;      // PC the Controller should see next
  int          count_m;     // queue occupancy after the coming edge
  bit          stale;       // outstanding request will be discarded

  // Responder / monitor state.
  bit          prev_req, prev_ack;
  logic [31:0] prev_addr;
  int          ack_wait;
  int          forced_delay;
  int          max_delay;
  int          ready_mode;  // 0 never, 1 always, 2 random
  bit          last_new_req;
  logic [31:0] last_new_addr;
  int          new_req_count;
  bit          wrap_on;
  logic [31:0] wrap_obs[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_fetch = 32'h0;
    exp_pc    = 32'h0;
    count_m   = 0;
    stale     = 0;
    prev_req  = 0;
    prev_ack  = 0;
    prev_addr = 0;
    ack_wait  = 0;
  endtask

  // One clock cycle: drive inputs after the rising edge, check and advance
  // the model on the falling edge.
  task automatic step(input logic br, input logic ub, input logic zf,
                      input logic [31:0] bpc, input logic [31:0] boff);
    bit          nreq, redir, pop;
    logic [31:0] tgt;
    @(posedge clock);
    #1;
    nreq = bus.imemReq && (!prev_req || prev_ack);
    if (nreq) begin
      ack_wait = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, max_delay));
      new_req_count++;
      last_new_addr = bus.imemAddr;
    end
    last_new_req = nreq;
    if (bus.imemReq && ack_wait == 0) begin
      bus.imemAck  = 1'b1;
      bus.imemData = mem_word(bus.imemAddr);
    end else begin
      bus.imemAck  = 1'b0;
      bus.imemData = $urandom;
      if (bus.imemReq) ack_wait--;
    end
    if (ready_mode == 2) bus.instReady = ($urandom_range(0, 3) != 0);
    else                 bus.instReady = (ready_mode == 1);
    bus.branchFlag              = br;
    bus.unconditionalBranchFlag = ub;
    bus.zeroFlag                = zf;
    bus.branchPc                = bpc;
    bus.branchOffset            = boff;

    @(negedge clock);
    if (wrap_on && wrap_obs.size() < 3 && bus2.imemReq) wrap_obs.push_back(bus2.imemAddr);
    check("queue_count", 64'(bus.queueCount), 64'(count_m));
    check("inst_valid", 64'(bus.instValid), 64'(count_m != 0));
    if (nreq) begin
      if (!stale) check("req_addr", 64'(bus.imemAddr), 64'(exp_fetch));
      check("req_has_space", 64'(count_m < QD), 64'(1));
    end
    if (bus.imemReq && prev_req && !prev_ack) check("addr_hold", 64'(bus.imemAddr), 64'(prev_addr));
    pop = (count_m != 0) && bus.instReady;
    if (pop) begin
      check("head_pc", 64'(bus.instPc), 64'(exp_pc));
      check("head_data", 64'(bus.instData), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 32'd4;
    end

    redir = ub | (br & zf);
    tgt   = bpc + (boff << 2);
    if (bus.imemReq && bus.imemAck) begin
      if (!stale && !redir) begin
        count_m++;
        exp_fetch = exp_fetch + 32'd4;
      end
      stale = 0;
    end
    if (pop) count_m--;
    if (redir) begin
      count_m   = 0;
      exp_fetch = tgt;
      exp_pc    = tgt;
      if (bus.imemReq && !bus.imemAck) stale = 1;
    end
    prev_req  = bus.imemReq;
    prev_ack  = bus.imemAck;
    prev_addr = bus.imemAddr;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic wait_new_req(input string tag);
    last_new_req = 0;
    for (int i = 0; i < 20 && !last_new_req; i++) idle_step();
    check(tag, 64'(last_new_req), 64'(1));
  endtask

  initial begin
    bus.imemAck = 0; bus.imemData = 0; bus.branchFlag = 0;
    bus.unconditionalBranchFlag = 0; bus.zeroFlag = 0;
    bus.branchPc = 0; bus.branchOffset = 0; bus.instReady = 0;
    forced_delay = 0; max_delay = 3; ready_mode = 1;
    new_req_count = 0; wrap_on = 0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_req", 64'(bus.imemReq), 64'(0));
    check("rst_addr", 64'(bus.imemAddr), 64'(0));
    check("rst_valid", 64'(bus.instValid), 64'(0));
    check("rst_data", 64'(bus.instData), 64'(0));
    check("rst_pc", 64'(bus.instPc), 64'(0));
    check("rst_count", 64'(bus.queueCount), 64'(0));
    check("rst_state", 64'(state1), 64'(0));
    check("rst_addr2", 64'(bus2.imemAddr), 64'(RESET2));
    resetN  = 1'b1;
    wrap_on = 1;

    // Streaming: single-cycle ack, Controller always ready.
    step(0, 0, 0, 0, 0);
    check("first_req", 64'(bus.imemReq), 64'(1));
    check("first_addr", 64'(bus.imemAddr), 64'(0));
    for (int i = 0; i < 10; i++) begin
      idle_step();
      if (i >= 2) check("stream_valid", 64'(bus.instValid), 64'(1));
    end

    // Wrap of the second instance's address stream.
    for (int i = 0; i < 3; i++) exp_q.push_back(RESET2 + 32'(4 * i));
    check("wrap_len", 64'(wrap_obs.size()), 64'(3));
    while (wrap_obs.size() > 0 && exp_q.size() > 0)
      check("wrap_addr", 64'(wrap_obs.pop_front()), 64'(exp_q.pop_front()));
    wrap_on = 0;

    // Fill the queue with the Controller stalled.
    ready_mode = 0;
    for (int i = 0; i < 12; i++) idle_step();
    check("full_count", 64'(bus.queueCount), 64'(QD));
    check("full_noreq", 64'(bus.imemReq), 64'(0));
    new_req_count = 0;
    ready_mode = 1;
    idle_step();
    ready_mode = 0;
    for (int i = 0; i < 6; i++) idle_step();
    check("one_refill", 64'(new_req_count), 64'(1));
    check("refull_count", 64'(bus.queueCount), 64'(QD));

    // Taken conditional branch with three entries queued.
    step(0, 1, 0, 32'h100, 32'h0);
    for (int i = 0; i < 30 && count_m != 3; i++) idle_step();
    check("fill3", 64'(count_m), 64'(3));
    step(1, 0, 1, 32'h20, 32'hFFFF_FFFE);
    idle_step();
    check("br_flush_count", 64'(bus.queueCount), 64'(0));
    check("br_flush_valid", 64'(bus.instValid), 64'(0));
    wait_new_req("br_req_seen");
    check("br_target", 64'(last_new_addr), 64'(32'h18));

    // Not-taken branch: no flush.
    for (int i = 0; i < 10; i++) idle_step();
    step(1, 0, 0, 32'h20, 32'hFFFF_FFFE);
    idle_step();
    check("nt_no_flush", 64'(bus.queueCount != 0), 64'(1));

    // Redirect while waiting on a slow ack.
    step(0, 1, 0, 32'h200, 32'h0);
    forced_delay = 3;
    wait_new_req("slow_req_seen");
    step(0, 1, 0, 32'h300, 32'h0);
    idle_step();
    check("drop_state", 64'(state1), 64'(2));
    wait_new_req("drop_req_seen");
    check("drop_target", 64'(last_new_addr), 64'(32'h300));
    check("drop_discard", 64'(bus.queueCount), 64'(0));

    // Redirect coincident with ack.
    forced_delay = 1;
    wait_new_req("coin_req_seen");
    step(0, 1, 0, 32'h400, 32'h0);
    idle_step();
    check("coin_state", 64'(state1), 64'(0));
    check("coin_count", 64'(bus.queueCount), 64'(0));
    wait_new_req("coin_req2_seen");
    check("coin_target", 64'(last_new_addr), 64'(32'h400));

    // Asynchronous reset while a request is outstanding.
    forced_delay = 6;
    ready_mode = 1;
    wait_new_req("rst_wait_seen");
    #2;
    resetN = 1'b0;
    #1;
    check("async_req", 64'(bus.imemReq), 64'(0));
    check("async_count", 64'(bus.queueCount), 64'(0));
    check("async_state", 64'(state1), 64'(0));
    bus.imemAck = 0;
    bus.unconditionalBranchFlag = 0;
    bus.branchFlag = 0;
    @(negedge clock);
    model_reset();
    resetN = 1'b1;
    forced_delay = 0;
    step(0, 0, 0, 0, 0);
    check("rerun_req", 64'(bus.imemReq), 64'(1));
    check("rerun_addr", 64'(bus.imemAddr), 64'(0));

    // Randomized phase.
    forced_delay = -1;
    max_delay    = 3;
    ready_mode   = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        logic        ub;
        logic [31:0] off;
        ub  = 1'($urandom_range(0, 1));
        off = 32'($urandom_range(0, 20)) - 32'd10;
        step(~ub, ub, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, off);
      end else begin
        idle_step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
